// File: rtl/mmips_ctrl_pkg.sv
// Shared encodings for the multi-cycle stack machine controller:
// opcodes, ALU operations and controller states.
package mmips_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_NOT  = 3'b011,
      OP_PUSH = 3'b100,
      OP_POP  = 3'b101,
      OP_JMP  = 3'b110,
      OP_JZ   = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_NOT = 2'b11
   } alu_op_e;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEM_RD  = 4'd2,
      S_PUSH_WB = 4'd3,
      S_POP_WR  = 4'd4,
      S_POP_DEL = 4'd5,
      S_JUMP    = 4'd6,
      S_JZ_CHK  = 4'd7,
      S_ALU_LDB = 4'd8,
      S_ALU_POP = 4'd9,
      S_ALU_WB  = 4'd10
   } state_e;

endpackage

// File: rtl/stack_controller.sv
// Multi-cycle control FSM for the stack machine datapath.
// Registered state, combinational next-state and output decode.
module stack_controller
   import mmips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] instruction,
   input  logic       z,
   output logic       ld_pc,
   output logic       ld_IR,
   output logic       ld_MDR,
   output logic       ld_B,
   output logic       pc_src,
   output logic       mem_adr_src,
   output logic       mem_write_sig,
   output logic       stack_src,
   output logic       push_sig,
   output logic       pop_sig,
   output logic       tos_sig,
   output logic [1:0] alu_op
);

   state_e  state_q, state_d;
   opcode_e opcode;
   logic    unused_addr;

   assign opcode      = opcode_e'(instruction[7:5]);
   assign unused_addr = ^instruction[4:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      ld_pc         = 1'b0;
      ld_IR         = 1'b0;
      ld_MDR        = 1'b0;
      ld_B          = 1'b0;
      pc_src        = 1'b0;
      mem_adr_src   = 1'b0;
      mem_write_sig = 1'b0;
      stack_src     = 1'b0;
      push_sig      = 1'b0;
      pop_sig       = 1'b0;
      tos_sig       = 1'b0;
      alu_op        = ALU_ADD;
      unique case (state_q)
         S_FETCH: begin
            mem_adr_src = 1'b1;
            ld_IR       = 1'b1;
            ld_pc       = 1'b1;
            state_d     = S_DECODE;
         end
         S_DECODE: begin
            tos_sig = 1'b1;
            unique case (opcode)
               OP_PUSH: state_d = S_MEM_RD;
               OP_POP:  state_d = S_POP_WR;
               OP_JMP:  state_d = S_JUMP;
               OP_JZ:   state_d = S_JZ_CHK;
               default: state_d = S_ALU_LDB;
            endcase
         end
         S_MEM_RD: begin
            ld_MDR  = 1'b1;
            state_d = S_PUSH_WB;
         end
         S_PUSH_WB: begin
            push_sig = 1'b1;
            state_d  = S_FETCH;
         end
         S_POP_WR: begin
            tos_sig       = 1'b1;
            mem_write_sig = 1'b1;
            state_d       = S_POP_DEL;
         end
         S_POP_DEL: begin
            pop_sig = 1'b1;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            ld_pc   = 1'b1;
            pc_src  = 1'b1;
            state_d = S_FETCH;
         end
         S_JZ_CHK: begin
            tos_sig = 1'b1;
            pc_src  = 1'b1;
            ld_pc   = z;
            state_d = S_FETCH;
         end
         S_ALU_LDB: begin
            tos_sig = 1'b1;
            ld_B    = 1'b1;
            alu_op  = instruction[6:5];
            state_d = (opcode == OP_NOT) ? S_ALU_WB : S_ALU_POP;
         end
         S_ALU_POP: begin
            pop_sig = 1'b1;
            alu_op  = instruction[6:5];
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            tos_sig   = 1'b1;
            stack_src = 1'b1;
            push_sig  = 1'b1;
            pop_sig   = 1'b1;
            alu_op    = instruction[6:5];
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      // Reset must silence every strobe at once, including FETCH's.
      if (!rst_n) begin
         ld_pc         = 1'b0;
         ld_IR         = 1'b0;
         ld_MDR        = 1'b0;
         ld_B          = 1'b0;
         pc_src        = 1'b0;
         mem_adr_src   = 1'b0;
         mem_write_sig = 1'b0;
         stack_src     = 1'b0;
         push_sig      = 1'b0;
         pop_sig       = 1'b0;
         tos_sig       = 1'b0;
         alu_op        = ALU_ADD;
      end
   end

endmodule

// File: tb/tb_stack_controller.sv
// Randomised scoreboard bench for stack_controller against a
// per-instruction step-table reference model.
module tb_stack_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] instruction;
   logic       z;
   logic       ld_pc, ld_IR, ld_MDR, ld_B, pc_src, mem_adr_src;
   logic       mem_write_sig, stack_src, push_sig, pop_sig, tos_sig;
   logic [1:0] alu_op;

   int checks   = 0;
   int failures = 0;

   logic [12:0] expq[$];
   string       nameq[$];

   always #5 clk = ~clk;

   stack_controller dut (
      .clk(clk), .rst_n(rst_n), .instruction(instruction), .z(z),
      .ld_pc(ld_pc), .ld_IR(ld_IR), .ld_MDR(ld_MDR), .ld_B(ld_B),
      .pc_src(pc_src), .mem_adr_src(mem_adr_src),
      .mem_write_sig(mem_write_sig), .stack_src(stack_src),
      .push_sig(push_sig), .pop_sig(pop_sig), .tos_sig(tos_sig),
      .alu_op(alu_op)
   );

   // Packing: ld_pc ld_IR ld_MDR ld_B pc_src mem_adr_src mem_write
   //          stack_src push pop tos alu_op[1:0]
   function automatic logic [12:0] pack(
      logic a, logic b, logic c, logic d, logic e, logic f,
      logic g, logic h, logic i, logic j, logic k, logic [1:0] op);
      return {a, b, c, d, e, f, g, h, i, j, k, op};
   endfunction

   function automatic int latency(logic [7:0] ir);
      case (ir[7:5])
         3'b100, 3'b101, 3'b011: return 4;
         3'b110, 3'b111:         return 3;
         default:                return 5;
      endcase
   endfunction

   // Expected outputs for step s of instruction ir (step 0 = fetch).
   function automatic logic [12:0] model(logic [7:0] ir, int s, logic zz);
      logic [1:0] a;
      a = ir[6:5];
      if (s == 0) return pack(1,1,0,0,0,1,0,0,0,0,0,2'b00);
      if (s == 1) return pack(0,0,0,0,0,0,0,0,0,0,1,2'b00);
      case (ir[7:5])
         3'b100: return (s == 2) ? pack(0,0,1,0,0,0,0,0,0,0,0,2'b00)
                                 : pack(0,0,0,0,0,0,0,0,1,0,0,2'b00);
         3'b101: return (s == 2) ? pack(0,0,0,0,0,0,1,0,0,0,1,2'b00)
                                 : pack(0,0,0,0,0,0,0,0,0,1,0,2'b00);
         3'b110: return pack(1,0,0,0,1,0,0,0,0,0,0,2'b00);
         3'b111: return pack(zz,0,0,0,1,0,0,0,0,0,1,2'b00);
         3'b011: return (s == 2) ? pack(0,0,0,1,0,0,0,0,0,0,1,a)
                                 : pack(0,0,0,0,0,0,0,1,1,1,1,a);
         default: begin
            if (s == 2) return pack(0,0,0,1,0,0,0,0,0,0,1,a);
            if (s == 3) return pack(0,0,0,0,0,0,0,0,0,1,0,a);
            return pack(0,0,0,0,0,0,0,1,1,1,1,a);
         end
      endcase
   endfunction

   always @(negedge clk) begin
      logic [12:0] act, e;
      string       n;
      if (expq.size() > 0) begin
         e   = expq.pop_front();
         n   = nameq.pop_front();
         act = {ld_pc, ld_IR, ld_MDR, ld_B, pc_src, mem_adr_src,
                mem_write_sig, stack_src, push_sig, pop_sig, tos_sig,
                alu_op};
         checks++;
         if (act !== e) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", n, act, e, $time);
         end
      end
   end

   task automatic reset_cycles(int n, string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst_n = 1'b0;
         z     = 1'($urandom);
         instruction = 8'($urandom);
         expq.push_back(13'd0);
         nameq.push_back(tag);
      end
   endtask

   // zf: 0/1 forces z in every cycle, 2 = random.
   // rst_step: step at which reset is asserted, -1 = none.
   task automatic run_instr(logic [7:0] ir, int zf, int rst_step,
                            string tag);
      int  lat;
      logic uses_ir;
      lat = latency(ir);
      uses_ir = (ir[7:5] inside {3'b000, 3'b001, 3'b010, 3'b011});
      for (int s = 0; s < lat; s++) begin
         if (s == rst_step) begin
            reset_cycles(1 + int'($urandom_range(0, 2)), {tag, "_rst"});
            return;
         end
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         z = (zf == 2) ? 1'($urandom) : 1'(zf);
         if (s == 0 || (s >= 2 && !uses_ir))
            instruction = 8'($urandom);
         else
            instruction = ir;
         expq.push_back(model(ir, s, z));
         nameq.push_back($sformatf("%s_s%0d", tag, s));
      end
   endtask

   initial begin
      logic [7:0] ir;
      int rs;
      rst_n = 1'b0;
      z = 1'b0;
      instruction = 8'h00;
      reset_cycles(3, "reset");
      run_instr(8'h85, 2, -1, "push5");
      run_instr(8'h03, 2, -1, "add");
      run_instr(8'hE9, 1, -1, "jz_taken");
      run_instr(8'hE9, 0, -1, "jz_not");
      run_instr(8'h72, 2, -1, "not");
      run_instr(8'hA4, 2, -1, "pop4");
      run_instr(8'hDF, 2, -1, "jmp31");
      run_instr(8'h3F, 2, -1, "sub");
      run_instr(8'h5A, 2, -1, "and");
      run_instr(8'h03, 2, 3, "add_rst_alupop");
      run_instr(8'h85, 2, 3, "push_rst_wb");
      run_instr(8'hA4, 2, 2, "pop_rst_wr");
      for (int k = 0; k < 300; k++) begin
         ir = 8'($urandom);
         rs = ($urandom_range(0, 14) == 0)
              ? int'($urandom_range(1, latency(ir) - 1)) : -1;
         run_instr(ir, 2, rs, "rand");
      end
      run_instr(8'h00, 2, -1, "tail");
      repeat (3) @(posedge clk);
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d exp=0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
